// File: rtl/disaster_alert_engine_if.sv
// Sensor-sample, operator and panel-output signals of the disaster alert engine.
// The engine binds to the slave modport; the sensor front-end/panel side uses master.
interface disaster_alert_engine_if #(
    parameter int unsigned W = 7
);
    logic         sample_valid;
    logic [W-1:0] rain;
    logic [W-1:0] seismic;
    logic [W-1:0] wind;
    logic [W-1:0] sea;
    logic         mode;
    logic         ack;
    logic         flood_led;
    logic         cyclone_led;
    logic         earthquake_led;
    logic         tsunami_led;
    logic         safe_led;
    logic         danger_led;
    logic         buzzer;
    logic [1:0]   alarm_state;

    modport slave (
        input  sample_valid, rain, seismic, wind, sea, mode, ack,
        output flood_led, cyclone_led, earthquake_led, tsunami_led,
               safe_led, danger_led, buzzer, alarm_state
    );

    modport master (
        output sample_valid, rain, seismic, wind, sea, mode, ack,
        input  flood_led, cyclone_led, earthquake_led, tsunami_led,
               safe_led, danger_led, buzzer, alarm_state
    );
endinterface

// File: rtl/disaster_alert_engine.sv
// Four-hazard classifier with per-flag persistence filtering, an acknowledgeable
// alarm FSM and registered panel outputs.
module disaster_alert_engine #(
    parameter int unsigned W       = 7,
    parameter int unsigned PERSIST = 4,
    parameter int unsigned R_T1    = 2,
    parameter int unsigned R_T2    = 10,
    parameter int unsigned R_T3    = 30,
    parameter int unsigned S_T1    = 2,
    parameter int unsigned S_T2    = 6,
    parameter int unsigned S_T3    = 15,
    parameter int unsigned W_T1    = 16,
    parameter int unsigned W_T2    = 30,
    parameter int unsigned W_T3    = 60,
    parameter int unsigned L_T1    = 6,
    parameter int unsigned L_T2    = 20,
    parameter int unsigned L_T3    = 50
) (
    input logic clk,
    input logic rst_n,
    disaster_alert_engine_if.slave bus
);
    localparam int unsigned CW = $clog2(PERSIST) + 1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(PERSIST);

    typedef enum logic [1:0] {
        SAFE  = 2'd0,
        ALERT = 2'd1,
        ACKED = 2'd2
    } state_t;

    function automatic logic [1:0] level(input logic [W-1:0] x,
                                         input logic [W-1:0] t1,
                                         input logic [W-1:0] t2,
                                         input logic [W-1:0] t3);
        return 2'(x >= t1) + 2'(x >= t2) + 2'(x >= t3);
    endfunction

    logic [1:0]    r_lvl, s_lvl, w_lvl, l_lvl;
    logic [3:0]    raw;     // [0] flood, [1] cyclone, [2] earthquake, [3] tsunami
    logic [3:0]    conf;
    logic [3:0]    conf_d;
    logic [CW-1:0] cnt [4];
    logic          rise;
    logic [3:0]    sel;
    logic [3:0]    leds;
    logic          safe_q, danger_q, buzzer_q;
    state_t        state, state_next;

    always_comb begin
        r_lvl  = level(bus.rain,    W'(R_T1), W'(R_T2), W'(R_T3));
        s_lvl  = level(bus.seismic, W'(S_T1), W'(S_T2), W'(S_T3));
        w_lvl  = level(bus.wind,    W'(W_T1), W'(W_T2), W'(W_T3));
        l_lvl  = level(bus.sea,     W'(L_T1), W'(L_T2), W'(L_T3));
        raw[0] = (r_lvl >= 2'd2) & ((w_lvl >= 2'd2) | (l_lvl >= 2'd2) | (r_lvl == 2'd3));
        raw[1] = (w_lvl >= 2'd2) & ((w_lvl == 2'd3) | (l_lvl >= 2'd2) | (r_lvl >= 2'd2));
        raw[2] = (s_lvl >= 2'd1);
        raw[3] = (s_lvl == 2'd3) | (l_lvl >= 2'd2);
    end

    // A flag flips only after PERSIST valid samples disagree with it; invalid cycles hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conf   <= '0;
            conf_d <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            conf_d <= conf;
            if (bus.sample_valid) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (raw[i] == conf[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] + ONE == LIMIT) begin
                        conf[i] <= ~conf[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + ONE;
                    end
                end
            end
        end
    end

    // conf_d lags conf by one edge, so rise is seen by the FSM the cycle after the flag sets.
    assign rise = |(conf & ~conf_d);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= SAFE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SAFE:    if (|conf) state_next = ALERT;
            ALERT:   if (bus.ack) state_next = (|conf) ? ACKED : SAFE;
            ACKED: begin
                if (rise)        state_next = ALERT;
                else if (~|conf) state_next = SAFE;
            end
            default: state_next = SAFE;
        endcase
    end

    always_comb begin
        sel = '0;
        if (bus.mode)     sel = conf;
        else if (conf[3]) sel[3] = 1'b1;
        else if (conf[2]) sel[2] = 1'b1;
        else if (conf[1]) sel[1] = 1'b1;
        else if (conf[0]) sel[0] = 1'b1;
    end

    // Indicators are decoded from state_next so they land on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds     <= '0;
            safe_q   <= 1'b1;
            danger_q <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            leds     <= sel;
            safe_q   <= (state_next == SAFE);
            danger_q <= (state_next != SAFE);
            buzzer_q <= (state_next == ALERT);
        end
    end

    assign bus.flood_led      = leds[0];
    assign bus.cyclone_led    = leds[1];
    assign bus.earthquake_led = leds[2];
    assign bus.tsunami_led    = leds[3];
    assign bus.safe_led       = safe_q;
    assign bus.danger_led     = danger_q;
    assign bus.buzzer         = buzzer_q;
    assign bus.alarm_state    = state;
endmodule

// File: tb/tb_disaster_alert_engine.sv
// Scoreboard bench for disaster_alert_engine: a reference model queues the expected
// panel outputs per cycle, plus directed spot checks at the key scenario points.
module tb_disaster_alert_engine;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic md = 1'b0;

    always #5 clk = ~clk;

    disaster_alert_engine_if #(.W(7)) bus ();

    disaster_alert_engine #(.W(7), .PERSIST(P)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Reference model state
    int         run [4];
    logic [3:0] mc = '0;
    logic       m_rise = 1'b0;
    int         mst = 0;
    logic [8:0] exp_q [$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lv(input int x, input int t1, input int t2, input int t3);
        int n = 0;
        int th [3];
        th[0] = t1; th[1] = t2; th[2] = t3;
        foreach (th[k]) if (x >= th[k]) n++;
        return n;
    endfunction

    function automatic logic [8:0] observed();
        return {bus.tsunami_led, bus.earthquake_led, bus.cyclone_led, bus.flood_led,
                bus.safe_led, bus.danger_led, bus.buzzer, bus.alarm_state};
    endfunction

    task automatic model_edge(input logic v, input int r, input int s, input int w,
                              input int l, input logic m, input logic a, input logic rn);
        logic [8:0] e;
        logic [3:0] led;
        logic [3:0] nc;
        logic [3:0] rw;
        int nst;
        int rl, sl, wl, ll;
        if (!rn) begin
            mc = '0; m_rise = 1'b0; mst = 0;
            foreach (run[i]) run[i] = 0;
            e = {4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
        end else begin
            nst = mst;
            if (mst == 0) begin
                if (mc != 0) nst = 1;
            end else if (mst == 1) begin
                if (a) nst = (mc != 0) ? 2 : 0;
            end else begin
                if (m_rise) nst = 1;
                else if (mc == 0) nst = 0;
            end
            if (m)          led = mc;
            else if (mc[3]) led = 4'b1000;
            else if (mc[2]) led = 4'b0100;
            else if (mc[1]) led = 4'b0010;
            else if (mc[0]) led = 4'b0001;
            else            led = 4'b0000;
            nc = mc;
            if (v) begin
                rl = lv(r, 2, 10, 30);
                sl = lv(s, 2, 6, 15);
                wl = lv(w, 16, 30, 60);
                ll = lv(l, 6, 20, 50);
                rw[3] = (sl == 3) || (ll >= 2);
                rw[2] = (sl >= 1);
                rw[1] = (wl >= 2) && ((wl == 3) || (ll >= 2) || (rl >= 2));
                rw[0] = (rl >= 2) && ((wl >= 2) || (ll >= 2) || (rl == 3));
                for (int i = 0; i < 4; i++) begin
                    if (rw[i] == mc[i]) run[i] = 0;
                    else begin
                        run[i]++;
                        if (run[i] == P) begin
                            nc[i] = ~mc[i];
                            run[i] = 0;
                        end
                    end
                end
            end
            m_rise = |(nc & ~mc);
            mc  = nc;
            mst = nst;
            e = {led, nst == 0, nst != 0, nst == 1, 2'(nst)};
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic v, input int r, input int s, input int w, input int l,
                       input logic a = 1'b0, input logic rn = 1'b1);
        logic [8:0] e;
        rst_n            = rn;
        bus.sample_valid = v;
        bus.rain         = 7'(r);
        bus.seismic      = 7'(s);
        bus.wind         = 7'(w);
        bus.sea          = 7'(l);
        bus.mode         = md;
        bus.ack          = a;
        model_edge(v, r, s, w, l, md, a, rn);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check("cycle_out", 16'(observed()), 16'(e));
        end
    endtask

    task automatic idle(input int n, input logic a = 1'b0);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0, a);
    endtask

    initial begin
        int hold;
        int r, s, w, l;
        logic v;
        foreach (run[i]) run[i] = 0;
        #1;
        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc(1'($urandom), $urandom_range(0, 127), $urandom_range(0, 127),
                $urandom_range(0, 127), $urandom_range(0, 127), 1'($urandom), 1'b0);
        check("rst_safe", bus.safe_led, 1);
        check("rst_danger", bus.danger_led, 0);
        check("rst_buzzer", bus.buzzer, 0);
        check("rst_state", bus.alarm_state, 0);
        check("rst_leds", {bus.tsunami_led, bus.earthquake_led, bus.cyclone_led, bus.flood_led}, 0);

        // Confirm seismic=20 in unique mode
        md = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 0, 20, 0, 0);
        check("conf_pre_state", bus.alarm_state, 0);
        idle(1);
        check("conf_ts", bus.tsunami_led, 1);
        check("conf_eq", bus.earthquake_led, 0);
        check("conf_buzz", bus.buzzer, 1);
        check("conf_danger", bus.danger_led, 1);
        check("conf_state", bus.alarm_state, 1);
        md = 1'b1;
        idle(1);
        check("mode1_eq", bus.earthquake_led, 1);
        check("mode1_ts", bus.tsunami_led, 1);

        // Ack, then a new flood hazard raises the alarm again
        idle(1, 1'b1);
        check("ack_state", bus.alarm_state, 2);
        check("ack_buzz", bus.buzzer, 0);
        check("ack_danger", bus.danger_led, 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 35, 20, 0, 0);
        check("flood_pre_state", bus.alarm_state, 2);
        idle(1);
        check("rise_state", bus.alarm_state, 1);
        check("rise_buzz", bus.buzzer, 1);
        check("rise_flood", bus.flood_led, 1);

        // Clear from ACKED
        idle(1, 1'b1);
        check("ack2_state", bus.alarm_state, 2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 0, 0, 0, 0);
        idle(1);
        check("clear_state", bus.alarm_state, 0);
        check("clear_safe", bus.safe_led, 1);

        // ALERT persists with C==0 until ack
        for (int i = 0; i < 4; i++) cyc(1'b1, 0, 20, 0, 0);
        idle(1);
        check("realert", bus.alarm_state, 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 0, 0, 0, 0);
        idle(2);
        check("alert_hold", bus.alarm_state, 1);
        check("alert_hold_leds", {bus.tsunami_led, bus.earthquake_led, bus.cyclone_led, bus.flood_led}, 0);
        idle(1, 1'b1);
        check("alert_ack_safe", bus.alarm_state, 0);

        // Glitch reject, then a gapped run that still confirms
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 20, 0, 0);
        cyc(1'b1, 0, 0, 0, 0);
        idle(2);
        check("glitch_state", bus.alarm_state, 0);
        check("glitch_eq", bus.earthquake_led, 0);
        cyc(1'b1, 0, 20, 0, 0); idle(1);
        cyc(1'b1, 0, 20, 0, 0); idle(2);
        cyc(1'b1, 0, 20, 0, 0); idle(1);
        cyc(1'b1, 0, 20, 0, 0); idle(1);
        check("gap_state", bus.alarm_state, 1);
        check("gap_eq", bus.earthquake_led, 1);

        // Rise beats ack in ACKED; reset during ALERT
        idle(1, 1'b1);
        check("pri_acked", bus.alarm_state, 2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 35, 20, 0, 0, 1'b1);
        check("pri_hold", bus.alarm_state, 2);
        idle(1, 1'b1);
        check("pri_rise", bus.alarm_state, 1);
        cyc(1'b0, 0, 20, 0, 0, 1'b0, 1'b0);
        check("mid_rst_state", bus.alarm_state, 0);
        check("mid_rst_safe", bus.safe_led, 1);
        idle(1);

        // Randomised held samples covering wind/sea levels and cyclone
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 60);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 0;
            w = $urandom_range(0, 90);
            l = $urandom_range(0, 70);
            md = 1'($urandom);
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                v = ($urandom_range(0, 3) != 0);
                cyc(v, r, s, w, l, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
